// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for MEM-stage loads and stores.
// Owns a single-port word RAM with a registered read. Loads return extended
// data one cycle later. SB/SH perform a two-cycle read-modify-write that
// stalls the requester for one cycle. Misaligned or illegal requests are
// dropped and flagged.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  misalign_err
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  typedef enum logic {IDLE, RMW} state_t;

  state_t state_reg, state_next;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rd_word_reg;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_off;
  logic             load_ok, store_ok, acc_ok;
  logic             ram_re, ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      wrep;
  logic [3:0]       byte_en;
  logic [31:0]      merged;
  logic             rsp_valid_reg, rsp_valid_next;
  logic             load_err_reg, load_err_next;
  logic             misalign_reg, misalign_next;
  logic [1:0]       off_reg;
  logic [2:0]       funct3_reg;
  logic [31:0]      shifted;
  logic [31:0]      ext_data;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign byte_off = req_addr[1:0];

  // Legality of the presented request for loads and stores separately.
  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~byte_off[0];
      3'b010:         load_ok = (byte_off == 2'b00);
      default:        load_ok = 1'b0;
    endcase
    case (req_funct3)
      3'b000:  store_ok = 1'b1;
      3'b001:  store_ok = ~byte_off[0];
      3'b010:  store_ok = (byte_off == 2'b00);
      default: store_ok = 1'b0;
    endcase
    acc_ok = req_we ? store_ok : load_ok;
  end

  // Sub-word store lane selection: data replicated across lanes, enables pick the target.
  always_comb begin
    wrep    = (req_funct3[1:0] == 2'b00) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
    byte_en = (req_funct3[1:0] == 2'b00) ? (4'b0001 << byte_off)
                                         : (byte_off[1] ? 4'b1100 : 4'b0011);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_en[gi] ? wrep[8*gi +: 8] : rd_word_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state, RAM control and next-cycle response decode.
  always_comb begin
    state_next     = state_reg;
    stall          = 1'b0;
    ram_re         = 1'b0;
    ram_we         = 1'b0;
    ram_wdata      = req_wdata;
    rsp_valid_next = 1'b0;
    load_err_next  = 1'b0;
    misalign_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_en) begin
          if (!acc_ok) begin
            misalign_next  = 1'b1;
            rsp_valid_next = ~req_we;
            load_err_next  = ~req_we;
          end else if (!req_we) begin
            ram_re         = 1'b1;
            rsp_valid_next = 1'b1;
          end else if (req_funct3 == 3'b010) begin
            ram_we = 1'b1;
          end else begin
            ram_re     = 1'b1;
            stall      = 1'b1;
            state_next = RMW;
          end
        end
      end
      RMW: begin
        // Request is still held; req_en is not consulted here.
        ram_we     = 1'b1;
        ram_wdata  = merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-port RAM with registered read; reset suppresses any pending write.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      mem[word_idx] <= ram_wdata;
    end else if (ram_re && !rst) begin
      rd_word_reg <= mem[word_idx];
    end
  end

  // State and registered response bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rsp_valid_reg <= 1'b0;
      load_err_reg  <= 1'b0;
      misalign_reg  <= 1'b0;
      off_reg       <= 2'b00;
      funct3_reg    <= 3'b000;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= rsp_valid_next;
      load_err_reg  <= load_err_next;
      misalign_reg  <= misalign_next;
      off_reg       <= byte_off;
      funct3_reg    <= req_funct3;
    end
  end

  // Load data extraction from the registered RAM word.
  always_comb begin
    shifted = rd_word_reg >> {off_reg, 3'b000};
    case (funct3_reg)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_data = {24'h000000, shifted[7:0]};
      3'b101:  ext_data = {16'h0000, shifted[15:0]};
      default: ext_data = rd_word_reg;
    endcase
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rdata    = (rsp_valid_reg && !load_err_reg) ? ext_data : 32'h0000_0000;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed cases plus randomized traffic
// checked against an array-based memory model with arithmetic extraction.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_en;
  logic        req_we;
  logic [11:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [1024];

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_WIDTH(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_en      (req_en),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input bit we, input int unsigned addr, input int unsigned f3);
    if (we)
      return (f3 == 0) || (f3 == 1 && addr % 2 == 0) || (f3 == 2 && addr % 4 == 0);
    return (f3 == 0) || (f3 == 4) || ((f3 == 1 || f3 == 5) && addr % 2 == 0) ||
           (f3 == 2 && addr % 4 == 0);
  endfunction

  function automatic logic [31:0] model_load(input int unsigned addr, input int unsigned f3);
    logic [31:0] w, b, h;
    int unsigned sh;
    w  = model_mem[addr / 4];
    sh = 8 * (addr % 4);
    b  = (w >> sh) & 32'hFF;
    h  = (w >> sh) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4:       return b;
      5:       return h;
      default: return w;
    endcase
  endfunction

  function automatic void model_store(input int unsigned addr, input int unsigned f3,
                                      input logic [31:0] wd);
    int unsigned idx, sh;
    idx = addr / 4;
    sh  = 8 * (addr % 4);
    if (f3 == 0)
      model_mem[idx] = (model_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    else if (f3 == 1)
      model_mem[idx] = (model_mem[idx] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    else
      model_mem[idx] = wd;
  endfunction

  // One request: checks the combinational stall, the next-cycle response,
  // and for sub-word stores the RMW cycle. Consumes 1 or 2 clock cycles.
  task automatic access(input bit we, input int unsigned addr, input int unsigned f3,
                        input logic [31:0] wd);
    bit          legal, sub;
    logic [31:0] exp_data;
    legal    = model_legal(we, addr, f3);
    sub      = we && legal && (f3 != 2);
    exp_data = (!we && legal) ? model_load(addr, f3) : 32'h0;
    @(negedge clk);
    req_en     = 1'b1;
    req_we     = we;
    req_addr   = addr[11:0];
    req_funct3 = f3[2:0];
    req_wdata  = wd;
    #1;
    check("stall", {31'b0, stall}, {31'b0, sub});
    @(posedge clk);
    #1;
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, !we});
    check("rsp_rdata", rsp_rdata, exp_data);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, !legal});
    if (sub) begin
      @(negedge clk);
      #1;
      check("stall_rmw", {31'b0, stall}, 32'h0);
      @(posedge clk);
      #1;
      check("rsp_valid_rmw", {31'b0, rsp_valid}, 32'h0);
      check("misalign_rmw", {31'b0, misalign_err}, 32'h0);
    end
    if (we && legal) model_store(addr, f3, wd);
    $display("txn we=%0d addr=0x%03h f3=%0d wdata=0x%08h rdata=0x%08h legal=%0d",
             we, addr, f3, wd, rsp_rdata, legal);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_en     = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_addr   = 12'($urandom_range(0, 4095));
    req_funct3 = 3'($urandom_range(0, 7));
    req_wdata  = $urandom;
    #1;
    check("idle_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    check("idle_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("idle_rsp_rdata", rsp_rdata, 32'h0);
    check("idle_misalign", {31'b0, misalign_err}, 32'h0);
    $display("txn idle");
  endtask

  initial begin
    int unsigned a;
    rst        = 1'b1;
    req_en     = 1'b0;
    req_we     = 1'b0;
    req_addr   = 12'h0;
    req_funct3 = 3'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Known contents for words 0..63 and the top word.
    for (int i = 0; i < 64; i++) access(1'b1, 4 * i, 2, $urandom);
    access(1'b1, 12'hFFC, 2, $urandom);

    // Store then immediate load of the same word.
    access(1'b1, 12'h010, 2, 32'hDEAD_BEEF);
    access(1'b0, 12'h010, 2, 32'h0);
    check("lw_deadbeef", rsp_rdata, 32'hDEAD_BEEF);

    // Byte store merge.
    access(1'b1, 12'h010, 2, 32'h1122_3344);
    access(1'b1, 12'h011, 0, 32'h0000_00AA);
    access(1'b0, 12'h010, 2, 32'h0);
    check("sb_merge", rsp_rdata, 32'h1122_AA44);

    // Extension cases.
    access(1'b1, 12'h020, 2, 32'h80FF_7F01);
    access(1'b0, 12'h021, 0, 32'h0);
    check("lb_7f", rsp_rdata, 32'h0000_007F);
    access(1'b0, 12'h023, 0, 32'h0);
    check("lb_80", rsp_rdata, 32'hFFFF_FF80);
    access(1'b0, 12'h022, 4, 32'h0);
    check("lbu_ff", rsp_rdata, 32'h0000_00FF);
    access(1'b0, 12'h022, 1, 32'h0);
    check("lh_80ff", rsp_rdata, 32'hFFFF_80FF);
    access(1'b0, 12'h022, 5, 32'h0);
    check("lhu_80ff", rsp_rdata, 32'h0000_80FF);

    // Misaligned accesses.
    access(1'b1, 12'h014, 2, 32'h5A5A_1234);
    access(1'b0, 12'h013, 2, 32'h0);
    access(1'b1, 12'h015, 1, 32'h0000_BEEF);
    access(1'b0, 12'h014, 2, 32'h0);
    check("sh_misalign_nowrite", rsp_rdata, 32'h5A5A_1234);

    // Reset during RMW must drop the write.
    @(negedge clk);
    req_en     = 1'b1;
    req_we     = 1'b1;
    req_addr   = 12'h02A;
    req_funct3 = 3'h1;
    req_wdata  = 32'h0000_C0DE;
    #1;
    check("rst_rmw_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    req_en = 1'b0;
    #1;
    check("rst_rmw_stall_after", {31'b0, stall}, 32'h0);
    check("rst_rmw_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rmw_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rmw_misalign", {31'b0, misalign_err}, 32'h0);
    $display("txn reset during RMW");
    access(1'b0, 12'h028, 2, 32'h0);

    // Back-to-back word loads.
    for (int i = 0; i < 8; i++) access(1'b0, 12'h040 + 4 * i, 2, 32'h0);

    idle_cycle();

    // Randomized traffic over the initialized region and the top word.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) a = 12'hFFC + $urandom_range(0, 3);
      else a = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) idle_cycle();
      else access(1'($urandom_range(0, 1)), a, $urandom_range(0, 7), $urandom);
    end

    idle_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
